// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command parsers: ASCII codes,
// parser states and time-field range limits.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_T    = 8'h54;
  localparam logic [7:0] CMD_t    = 8'h74;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  typedef enum logic [2:0] {
    IDLE,
    DIGITS,
    WAIT_EOL,
    CHECK,
    ACK
  } parser_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combinational conversion of a two-digit decimal field to binary.
module bcd_pair_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] value
);

  assign value = ({3'b000, tens} * 7'd10) + {3'b000, units};

endmodule

// File: rtl/uart_time_set_parser.sv
// Parses "T/t hhmmss CR/LF" from the UART RX FIFO, loads the watch time on a
// valid command and pushes a one-byte acknowledge into the UART TX FIFO.
module uart_time_set_parser
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_TICKS = 100,
  parameter logic [7:0] ACK_OK        = 8'h4B,
  parameter logic [7:0] ACK_ERR       = 8'h45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100hz,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  parser_state_t state;
  logic [3:0]    digits [6];
  logic [2:0]    cnt;
  logic [TW-1:0] tmo;
  logic [7:0]    ack_byte;
  logic          range_ok_q;

  logic [6:0] hour_bin, min_bin, sec_bin;
  logic       range_ok;
  logic       in_cmd;
  logic       timeout;

  bcd_pair_to_bin u_hour (.tens(digits[0]), .units(digits[1]), .value(hour_bin));
  bcd_pair_to_bin u_min  (.tens(digits[2]), .units(digits[3]), .value(min_bin));
  bcd_pair_to_bin u_sec  (.tens(digits[4]), .units(digits[5]), .value(sec_bin));

  assign range_ok = (hour_bin <= HOUR_MAX) && (min_bin <= MINSEC_MAX) && (sec_bin <= MINSEC_MAX);

  // Pop and push are combinational so the FIFOs see them in the same cycle
  // as rx_empty/tx_full; both are suppressed while reset is held.
  assign rx_rd   = !rst && !rx_empty && (state inside {IDLE, DIGITS, WAIT_EOL});
  assign tx_wr   = !rst && (state == ACK) && !tx_full;
  assign tx_data = tx_wr ? ack_byte : 8'h00;
  assign busy    = (state != IDLE);

  assign in_cmd  = (state == DIGITS) || (state == WAIT_EOL);
  // A pop in the same cycle as a tick wins, so the tick is ignored.
  assign timeout = in_cmd && !rx_rd && tick_100hz && (tmo == TW'(TIMEOUT_TICKS - 1));

  // NOTE: the digit slots are plain storage with no reset; every slot is
  // rewritten by a new command before the range check reads it.
  always_ff @(posedge clk) begin
    if ((state == DIGITS) && rx_rd && is_digit(rx_data)) begin
      digits[cnt] <= rx_data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rx_rd || !in_cmd) begin
      tmo <= '0;
    end else if (tick_100hz) begin
      tmo <= tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      ack_byte   <= 8'h00;
      range_ok_q <= 1'b0;
      set_valid  <= 1'b0;
      set_hour   <= 5'd0;
      set_min    <= 6'd0;
      set_sec    <= 6'd0;
      err        <= 1'b0;
    end else begin
      set_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_rd && ((rx_data == CMD_T) || (rx_data == CMD_t))) begin
            cnt   <= 3'd0;
            state <= DIGITS;
          end
        end
        DIGITS: begin
          if (rx_rd) begin
            if (is_digit(rx_data)) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd5) state <= WAIT_EOL;
            end else begin
              ack_byte <= ACK_ERR;
              err      <= 1'b1;
              state    <= ACK;
            end
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        WAIT_EOL: begin
          if (rx_rd) begin
            if (is_eol(rx_data)) begin
              // All six digits are already stored, so the load is registered
              // here and becomes visible in the CHECK cycle.
              range_ok_q <= range_ok;
              if (range_ok) begin
                set_valid <= 1'b1;
                set_hour  <= hour_bin[4:0];
                set_min   <= min_bin[5:0];
                set_sec   <= sec_bin[5:0];
              end
              state <= CHECK;
            end else begin
              ack_byte <= ACK_ERR;
              err      <= 1'b1;
              state    <= ACK;
            end
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        CHECK: begin
          ack_byte <= range_ok_q ? ACK_OK : ACK_ERR;
          err      <= !range_ok_q;
          state    <= ACK;
        end
        ACK: begin
          if (tx_wr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_set_parser.sv
// Directed self-checking bench for uart_time_set_parser with a queue-based
// RX FIFO model and negedge event monitors.
module tb_uart_time_set_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_100hz;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       tx_full;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       set_valid;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       err;
  logic       busy;

  uart_time_set_parser #(
    .TIMEOUT_TICKS(100),
    .ACK_OK       (8'h4B),
    .ACK_ERR      (8'h45)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_100hz(tick_100hz),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rx_rd     (rx_rd),
    .tx_full   (tx_full),
    .tx_wr     (tx_wr),
    .tx_data   (tx_data),
    .set_valid (set_valid),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         tx_cnt = 0;
  int         err_cnt = 0;
  int         sv_cnt = 0;
  int         pop_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  int         sv_h = 0, sv_m = 0, sv_s = 0;
  int         sv_cyc = 0, eol_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_rx();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endtask

  // RX FIFO model: consume the head byte on every pop, then present the next.
  always @(posedge clk) begin
    cyc++;
    if (rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
    #1 drive_rx();
  end

  always @(negedge clk) begin
    if (tx_wr) begin
      tx_cnt++;
      last_tx = tx_data;
    end
    if (err) err_cnt++;
    if (set_valid) begin
      sv_cnt++;
      sv_h   = int'(set_hour);
      sv_m   = int'(set_min);
      sv_s   = int'(set_sec);
      sv_cyc = cyc;
    end
    if (rx_rd) begin
      pop_cnt++;
      if (rx_data == 8'h0D || rx_data == 8'h0A) eol_cyc = cyc;
    end
  end

  task automatic send(input string s);
    @(posedge clk);
    #2;
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    drive_rx();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rx_empty && !busy) && n < budget);
    check({tag, " quiet"}, {31'd0, rx_empty && !busy}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #2 tick_100hz = 1'b1;
    @(posedge clk);
    #2 tick_100hz = 1'b0;
  endtask

  task automatic check_good(input string tag, input string cmd,
                            input int h, input int m, input int s);
    int t0, e0, v0;
    t0 = tx_cnt; e0 = err_cnt; v0 = sv_cnt;
    send(cmd);
    wait_quiet(tag, 100);
    check({tag, " set_valid count"}, sv_cnt - v0, 1);
    check({tag, " hour"}, sv_h, h);
    check({tag, " min"}, sv_m, m);
    check({tag, " sec"}, sv_s, s);
    check({tag, " ack count"}, tx_cnt - t0, 1);
    check({tag, " ack byte"}, last_tx, 8'h4B);
    check({tag, " err count"}, err_cnt - e0, 0);
    check({tag, " latency"}, sv_cyc - eol_cyc, 1);
  endtask

  task automatic check_bad(input string tag, input string cmd);
    int t0, e0, v0;
    t0 = tx_cnt; e0 = err_cnt; v0 = sv_cnt;
    send(cmd);
    wait_quiet(tag, 100);
    check({tag, " set_valid count"}, sv_cnt - v0, 0);
    check({tag, " ack count"}, tx_cnt - t0, 1);
    check({tag, " ack byte"}, last_tx, 8'h45);
    check({tag, " err count"}, err_cnt - e0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e0, v0, p0, n;
    rst = 1'b1;
    tick_100hz = 1'b0;
    tx_full = 1'b0;
    drive_rx();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rx_rd", rx_rd, 0);
    check("reset tx_wr/tx_data", {tx_wr, tx_data}, 0);
    check("reset set_valid/err", {set_valid, err}, 0);
    check("reset set_*", {set_hour, set_min, set_sec}, 0);
    check("reset busy", busy, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1: basic command
    check_good("t1", "T123456\r", 12, 34, 56);
    check("t1 tx_data idle", tx_data, 0);

    // 2: upper bounds accepted, hour 24 rejected with set_* held
    check_good("t2a", "t235959\n", 23, 59, 59);
    check_bad("t2b", "T240000\r");
    check("t2b held time", {set_hour, set_min, set_sec}, {5'd23, 6'd59, 6'd59});

    // 3: bad digit aborts; trailing bytes discarded silently
    check_bad("t3", "T12a456\r");

    // 4: inter-byte timeout, exact boundary
    t0 = tx_cnt; e0 = err_cnt; v0 = sv_cnt;
    send("T1234");
    cycles(10);
    check("t4 busy in command", busy, 1);
    for (int i = 0; i < 99; i++) tick();
    @(negedge clk);
    check("t4 busy after 99 ticks", busy, 1);
    tick();
    @(negedge clk);
    check("t4 busy after 100 ticks", busy, 0);
    check("t4 no ack/err/set", {tx_cnt - t0, err_cnt - e0, sv_cnt - v0}, 0);
    check_good("t4b", "T000000\r", 0, 0, 0);

    // 5: ack back-pressure
    @(posedge clk);
    #2 tx_full = 1'b1;
    t0 = tx_cnt; v0 = sv_cnt;
    send("T010203\r");
    n = 0;
    while (!rx_empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    cycles(3);
    check("t5 set_valid count", sv_cnt - v0, 1);
    check("t5 time", {sv_h[4:0], sv_m[5:0], sv_s[5:0]}, {5'd1, 6'd2, 6'd3});
    check("t5 busy while full", busy, 1);
    send("Z");
    p0 = pop_cnt;
    cycles(20);
    check("t5 no pops while full", pop_cnt - p0, 0);
    check("t5 no push while full", tx_cnt - t0, 0);
    @(posedge clk);
    #2 tx_full = 1'b0;
    @(negedge clk);
    check("t5 push on release", {tx_wr, tx_data}, {1'b1, 8'h4B});
    cycles(3);
    check("t5 single push", tx_cnt - t0, 1);
    check("t5 parsing resumed", {rx_empty, busy}, {1'b1, 1'b0});

    // 6: reset mid-command
    t0 = tx_cnt; e0 = err_cnt;
    send("T12");
    cycles(10);
    check("t6 busy before reset", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6 outputs in reset",
          {rx_rd, tx_wr, tx_data, set_valid, set_hour, set_min, set_sec, err, busy}, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    cycles(5);
    check("t6 no ack/err after reset", {tx_cnt - t0, err_cnt - e0}, 0);
    check_good("t6b", "T111111\r", 11, 11, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
